// File: rtl/a2d_scan_intf.sv
// Scanning A2D interface: single or swept 16-bit SPI conversions into a per-channel result bank.
// Latency: 2*(16*SCLK_DIV+1)+3 clks from start to cnv_cmplt; scan period 2*(16*SCLK_DIV+1)+4 clks.
// Backpressure: none; strt_cnv is only honoured in IDLE, requests arriving mid-conversion are dropped.
module a2d_scan_intf #(
  parameter int NUM_CHNNL = 8,
  parameter int RES_W     = 12,
  parameter int SCLK_DIV  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt_cnv,
  input  logic [2:0]       chnnl,
  input  logic             scan_en,
  input  logic [2:0]       rd_chnnl,
  input  logic             MISO,
  output logic             a2d_SS_n,
  output logic             SCLK,
  output logic             MOSI,
  output logic [RES_W-1:0] res,
  output logic [2:0]       res_chnnl,
  output logic             cnv_cmplt,
  output logic             scan_done,
  output logic [RES_W-1:0] rd_res
);

  localparam int              PH_W    = $clog2(SCLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(SCLK_DIV / 2 - 1);
  localparam logic [2:0]      LAST_CH = 3'(NUM_CHNNL - 1);

  typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, FIN} state_t;

  state_t           r_state;
  logic [PH_W-1:0]  r_phase;
  logic [4:0]       r_bit;
  logic             r_gap;
  logic [2:0]       r_ch;
  logic [2:0]       r_ptr;
  logic             r_scan;
  logic [15:0]      r_tx;
  logic [RES_W-1:0] r_rx;
  logic             r_ss_n;
  logic             r_sclk;
  logic [RES_W-1:0] r_res;
  logic [2:0]       r_res_ch;
  logic             r_cmplt;
  logic             r_scan_done;
  logic [RES_W-1:0] r_bank [NUM_CHNNL];

  logic             w_tx_end;
  logic             w_ph_last;
  logic [PH_W-1:0]  w_nxt_phase;
  logic             w_nxt_sclk;
  logic [2:0]       w_new_ch;
  logic [RES_W-1:0] w_rd_res;

  // Bit 16 is the single hold clk after the last SCLK period; the frame ends there.
  assign w_tx_end    = (r_bit == 5'd16);
  assign w_ph_last   = (r_phase == PH_LAST);
  assign w_nxt_phase = w_ph_last ? '0 : r_phase + PH_W'(1);
  // SCLK is low for the first half of a bit period; it stays high into the hold clk.
  assign w_nxt_sclk  = w_ph_last ? (r_bit == 5'd15) : (w_nxt_phase > PH_RISE);
  // A single request beats a pending scan and leaves the pointer alone.
  assign w_new_ch    = strt_cnv ? chnnl : r_ptr;

  // Conversion sequencer plus SPI engine; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_bit       <= '0;
      r_gap       <= 1'b0;
      r_ch        <= '0;
      r_ptr       <= '0;
      r_scan      <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_ss_n      <= 1'b1;
      r_sclk      <= 1'b1;
      r_res       <= '0;
      r_res_ch    <= '0;
      r_cmplt     <= 1'b0;
      r_scan_done <= 1'b0;
      for (int i = 0; i < NUM_CHNNL; i++) r_bank[i] <= '0;
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (strt_cnv || scan_en) begin
            r_ch    <= w_new_ch;
            r_scan  <= !strt_cnv;
            r_cmplt <= 1'b0;
            r_tx    <= {2'b00, w_new_ch, 11'h000};
            r_ss_n  <= 1'b0;
            r_sclk  <= 1'b0;
            r_phase <= '0;
            r_bit   <= '0;
            r_state <= TX1;
          end
        end
        TX1, TX2: begin
          if (w_tx_end) begin
            r_ss_n  <= 1'b1;
            r_gap   <= 1'b0;
            r_state <= (r_state == TX1) ? GAP : FIN;
          end else begin
            r_phase <= w_nxt_phase;
            r_sclk  <= w_nxt_sclk;
            // Sample on the clk where SCLK rises; only the low RES_W bits are kept.
            if (r_phase == PH_RISE) r_rx <= RES_W'({r_rx, MISO});
            if (w_ph_last) begin
              r_bit <= r_bit + 5'd1;
              r_tx  <= {r_tx[14:0], 1'b0};
            end
          end
        end
        GAP: begin
          if (r_gap) begin
            r_tx    <= {2'b00, r_ch, 11'h000};
            r_ss_n  <= 1'b0;
            r_sclk  <= 1'b0;
            r_phase <= '0;
            r_bit   <= '0;
            r_state <= TX2;
          end else begin
            r_gap <= 1'b1;
          end
        end
        FIN: begin
          r_res    <= r_rx;
          r_res_ch <= r_ch;
          r_cmplt  <= 1'b1;
          // Channels beyond the bank still report through res/res_chnnl.
          for (int i = 0; i < NUM_CHNNL; i++) begin
            if (r_ch == 3'(i)) r_bank[i] <= r_rx;
          end
          if (r_scan) begin
            if (r_ptr == LAST_CH) begin
              r_ptr       <= '0;
              r_scan_done <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 3'd1;
            end
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bank read port; unpopulated channels read as zero.
  always_comb begin
    w_rd_res = '0;
    for (int i = 0; i < NUM_CHNNL; i++) begin
      if (rd_chnnl == 3'(i)) w_rd_res = r_bank[i];
    end
  end

  assign a2d_SS_n  = r_ss_n;
  assign SCLK      = r_sclk;
  assign MOSI      = r_tx[15];
  assign res       = r_res;
  assign res_chnnl = r_res_ch;
  assign cnv_cmplt = r_cmplt;
  assign scan_done = r_scan_done;
  assign rd_res    = w_rd_res;

endmodule

// File: tb/tb_a2d_scan_intf.sv
// Bench for a2d_scan_intf: random ADC words, scan/single mixes, abort by reset.
// Expected results come from an ADC model and a channel/bank model kept here.
// Timing is checked against frame length, gap length and conversion period.
module tb_a2d_scan_intf;
  localparam int NUM = 4;
  localparam int RW  = 12;
  localparam int DIV = 4;
  localparam int T   = 16 * DIV + 1;
  localparam int PER = 2 * T + 4;
  localparam int CP  = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          strt_cnv = 1'b0;
  logic [2:0]    chnnl = '0;
  logic          scan_en = 1'b0;
  logic [2:0]    rd_chnnl = '0;
  logic          MISO = 1'b0;
  logic          a2d_SS_n, SCLK, MOSI;
  logic [RW-1:0] res, rd_res;
  logic [2:0]    res_chnnl;
  logic          cnv_cmplt, scan_done;

  a2d_scan_intf #(.NUM_CHNNL(NUM), .RES_W(RW), .SCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .chnnl(chnnl), .scan_en(scan_en),
    .rd_chnnl(rd_chnnl), .MISO(MISO), .a2d_SS_n(a2d_SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .res(res), .res_chnnl(res_chnnl), .cnv_cmplt(cnv_cmplt), .scan_done(scan_done),
    .rd_res(rd_res)
  );

  always #(CP/2) clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ADC model: fresh random word per frame, MSB first, next bit after each SCLK rise.
  logic [15:0] adc_w;
  int          bit_i;
  logic [15:0] adc_q[$];
  always @(negedge a2d_SS_n) begin
    adc_w = 16'($urandom);
    adc_q.push_back(adc_w);
    bit_i = 15;
    MISO  = adc_w[15];
  end
  always @(posedge SCLK) begin
    if (a2d_SS_n == 1'b0) begin
      #1;
      if (bit_i > 0) begin
        bit_i--;
        MISO = adc_w[bit_i];
      end
    end
  end

  // Bus monitor: command word, low length and start/end time of each frame.
  int          low_cnt = 0;
  logic [15:0] mosi_sh;
  logic [15:0] mosi_q[$];
  int          len_q[$];
  time         start_q[$];
  time         end_q[$];
  always @(posedge clk) if (!rst && a2d_SS_n == 1'b0) low_cnt++;
  always @(posedge SCLK) if (a2d_SS_n == 1'b0) mosi_sh = {mosi_sh[14:0], MOSI};
  always @(negedge a2d_SS_n) begin
    low_cnt = 0;
    mosi_sh = '0;
    start_q.push_back($time);
  end
  always @(posedge a2d_SS_n) begin
    if (!rst) begin
      mosi_q.push_back(mosi_sh);
      len_q.push_back(low_cnt);
      end_q.push_back($time);
    end
  end

  // Reference model state.
  logic [RW-1:0] bank_m [NUM];
  int            ptr_m = 0;

  task automatic clear_q();
    adc_q.delete(); mosi_q.delete(); len_q.delete(); start_q.delete(); end_q.delete();
  endtask

  // Waits for the next cnv_cmplt rise; n = clks from the launch edge (launch edge counts 1).
  task automatic wait_done(input int pulse_at, input int drop_at, output int n);
    logic prev;
    bit   done;
    prev = cnv_cmplt;
    done = 0;
    n    = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
      strt_cnv = (n == pulse_at);
      if (n == pulse_at) chnnl = 3'd1;
      if (n == drop_at) scan_en = 1'b0;
      if (cnv_cmplt === 1'b1 && prev !== 1'b1) done = 1;
      prev = cnv_cmplt;
    end
    if (!done) chk_eq("cmplt_timeout", 0, 1);
  endtask

  task automatic verify(input logic [2:0] ch, input bit is_scan);
    logic [15:0]   cmd;
    logic [RW-1:0] exp_r;
    cmd = {2'b00, ch, 11'h000};
    chk_eq("frame_cnt", mosi_q.size(), 2);
    chk_eq("adc_frame_cnt", adc_q.size(), 2);
    if (mosi_q.size() == 2 && adc_q.size() == 2 && len_q.size() == 2 &&
        start_q.size() == 2 && end_q.size() == 2) begin
      chk_eq("mosi_tx1", 32'(mosi_q[0]), 32'(cmd));
      chk_eq("mosi_tx2", 32'(mosi_q[1]), 32'(cmd));
      chk_eq("ss_low_tx1", len_q[0], T);
      chk_eq("ss_low_tx2", len_q[1], T);
      chk_eq("gap_clks", int'((start_q[1] - end_q[0]) / CP), 2);
      exp_r = adc_q[1][RW-1:0];
      chk_eq("res", 32'(res), 32'(exp_r));
      chk_eq("res_chnnl", 32'(res_chnnl), 32'(ch));
      chk_eq("cnv_cmplt", 32'(cnv_cmplt), 1);
      chk_eq("scan_done", 32'(scan_done), (is_scan && int'(ch) == NUM - 1) ? 1 : 0);
      if (int'(ch) < NUM) bank_m[ch] = exp_r;
      if (is_scan) ptr_m = (ptr_m == NUM - 1) ? 0 : ptr_m + 1;
    end
    clear_q();
    rd_chnnl = ch;
    #1;
    chk_eq("rd_res_after", 32'(rd_res), (int'(ch) < NUM) ? 32'(bank_m[ch]) : 0);
  endtask

  task automatic run_one(input logic [2:0] ch, input bit is_scan, input int pulse_at, input int drop_at);
    int n;
    wait_done(pulse_at, drop_at, n);
    chk_eq("period", n, PER);
    verify(ch, is_scan);
  endtask

  task automatic run_scan();
    run_one(3'(ptr_m), 1'b1, -1, -1);
  endtask

  task automatic bank_sweep();
    for (int c = 0; c < 8; c++) begin
      rd_chnnl = 3'(c);
      #1;
      chk_eq("bank_rd", 32'(rd_res), (c < NUM) ? 32'(bank_m[c]) : 0);
    end
  endtask

  task automatic idle_window(input int ncyc);
    int lows   = 0;
    int drops  = 0;
    int starts = 0;
    repeat (ncyc) begin
      @(posedge clk); #1;
      if (a2d_SS_n !== 1'b1) lows++;
      if (cnv_cmplt !== 1'b1) drops++;
    end
    starts = start_q.size();
    chk_eq("idle_ss_low", lows, 0);
    chk_eq("idle_cmplt_held", drops, 0);
    chk_eq("idle_new_frames", starts, 0);
  endtask

  initial begin
    logic [2:0] rch;
    for (int i = 0; i < NUM; i++) bank_m[i] = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk_eq("rst_ss_n", 32'(a2d_SS_n), 1);
    chk_eq("rst_sclk", 32'(SCLK), 1);
    chk_eq("rst_mosi", 32'(MOSI), 0);
    chk_eq("rst_res", 32'(res), 0);
    chk_eq("rst_res_chnnl", 32'(res_chnnl), 0);
    chk_eq("rst_cnv_cmplt", 32'(cnv_cmplt), 0);
    chk_eq("rst_scan_done", 32'(scan_done), 0);
    bank_sweep();
    clear_q();

    // Single conversion on a channel outside the bank: latency and frame shape.
    @(posedge clk); #1;
    strt_cnv = 1'b1; chnnl = 3'd5;
    run_one(3'd5, 1'b0, -1, -1);

    // Random single conversions.
    repeat (4) begin
      rch = 3'($urandom_range(0, 7));
      strt_cnv = 1'b1; chnnl = rch;
      run_one(rch, 1'b0, -1, -1);
    end

    // Scan from pointer 0, then a single request colliding with the scan at pointer 2.
    scan_en = 1'b1;
    run_scan();
    run_scan();
    strt_cnv = 1'b1; chnnl = 3'd6;
    run_one(3'd6, 1'b0, -1, -1);
    run_scan();
    run_scan();
    run_scan();

    // scan_en dropped inside TX1 of channel 1: it completes, then the bus goes quiet.
    run_one(3'(ptr_m), 1'b1, -1, 10);
    idle_window(300);
    scan_en = 1'b1;
    run_scan();
    scan_en = 1'b0;

    // strt_cnv pulsed during TX2 is ignored.
    strt_cnv = 1'b1; chnnl = 3'd3;
    run_one(3'd3, 1'b0, 70, -1);
    idle_window(300);
    bank_sweep();

    // Reset in the middle of TX1.
    strt_cnv = 1'b1; chnnl = 3'd1;
    repeat (20) begin @(posedge clk); #1; strt_cnv = 1'b0; end
    chk_eq("pre_rst_ss_n", 32'(a2d_SS_n), 0);
    #2 rst = 1'b1;
    #1;
    chk_eq("abort_ss_n", 32'(a2d_SS_n), 1);
    chk_eq("abort_sclk", 32'(SCLK), 1);
    chk_eq("abort_mosi", 32'(MOSI), 0);
    chk_eq("abort_res", 32'(res), 0);
    chk_eq("abort_res_chnnl", 32'(res_chnnl), 0);
    chk_eq("abort_cnv_cmplt", 32'(cnv_cmplt), 0);
    for (int i = 0; i < NUM; i++) bank_m[i] = '0;
    ptr_m = 0;
    bank_sweep();
    @(posedge clk); #3 rst = 1'b0;
    clear_q();
    #1;
    strt_cnv = 1'b1; chnnl = 3'd1;
    run_one(3'd1, 1'b0, -1, -1);
    scan_en = 1'b1;
    run_scan();
    scan_en = 1'b0;
    bank_sweep();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/a2d_scan_intf.md
# a2d_scan_intf

Parametrised successor to the single-shot A2D SPI interface. Runs single conversions on request or sweeps channels 0..NUM_CHNNL-1 continuously, keeping a per-channel result bank that the rest of the design can read at any time. Contains its own SPI master engine, so it connects directly to the off-chip ADC pins. Sits between the ADC and every block that consumes analog readings.

## Interface
- NUM_CHNNL, 8, number of channels swept in scan mode (1..8)
- RES_W, 12, result width; low RES_W bits of the 16-bit read frame (1..16)
- SCLK_DIV, 32, clk cycles per SCLK period (even, >= 4)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- strt_cnv  in  1  single-conversion request, sampled in IDLE
- chnnl  in  3  channel for a single conversion
- scan_en  in  1  level; while high, run back-to-back sweeps
- rd_chnnl  in  3  combinational read select into the result bank
- MISO  in  1  ADC serial data out
- a2d_SS_n  out  1  ADC slave select, active low
- SCLK  out  1  SPI clock, idles high
- MOSI  out  1  SPI data to ADC, MSB first
- res  out  RES_W  most recent conversion result
- res_chnnl  out  3  channel that produced res
- cnv_cmplt  out  1  level; set when a conversion finishes, cleared by the next start
- scan_done  out  1  one-clk pulse when channel NUM_CHNNL-1 finishes in scan mode
- rd_res  out  RES_W  bank[rd_chnnl]; 0 if rd_chnnl >= NUM_CHNNL

## Operation
- States: IDLE, TX1, GAP, TX2, FIN.
- Command frame: cmd = {2'b00, ch, 11'h000}, 16 bits. The same frame is sent in TX1 and TX2.
- Result: the TX2 read frame; res = rd_frame[RES_W-1:0].
- IDLE:
  - strt_cnv=1 → ch=chnnl, clear cnv_cmplt, go to TX1.
  - Otherwise, scan_en=1 → ch=scan pointer, clear cnv_cmplt, go to TX1.
  - If both are high, strt_cnv wins and the scan pointer is unchanged.
- TX1 and TX2 each run one 16-bit SPI transaction. When the transaction ends, TX1 → GAP and TX2 → FIN.
- GAP: a2d_SS_n held high for exactly 2 clks, then TX2.
- FIN (1 clk):
  - Load res and res_chnnl. Set cnv_cmplt.
  - If ch < NUM_CHNNL, write bank[ch].
  - Scan conversions only: advance the pointer, wrapping NUM_CHNNL-1 → 0; pulse scan_done on wrap.
  - Then IDLE. In scan mode the next conversion starts on the following clk.
- strt_cnv outside IDLE is ignored; there is no queueing.
- scan_en falling mid-conversion: the current conversion completes and is stored; no further scan conversion starts. The pointer keeps its value, so the next sweep resumes from it.
- Single conversions never move the scan pointer. They still write bank[chnnl] when chnnl < NUM_CHNNL.
- chnnl >= NUM_CHNNL: the conversion runs and updates res, res_chnnl and cnv_cmplt only.

## Timing
- SPI transaction:
  - a2d_SS_n goes low on the first TX clk.
  - 16 bit periods of SCLK_DIV clks each.
  - Within each bit period, SCLK is low for the first SCLK_DIV/2 clks and high for the rest.
  - MISO is sampled on the clk where SCLK rises. MOSI changes only at bit-period starts; bit 15 is valid from the a2d_SS_n fall.
  - One hold clk after the last period, with SCLK high.
  - a2d_SS_n low length T = 16*SCLK_DIV + 1 clks.
- Latency: with strt_cnv high at edge 0, a2d_SS_n is low for clks 1..T, high for 2 clks, then low for T+3..2T+2. FIN is at clk 2T+3, and cnv_cmplt, res and the bank update are visible after that edge.
  - SCLK_DIV=32 → cnv_cmplt at clk 1029.
  - SCLK_DIV=4 → cnv_cmplt at clk 133.
- Scan period per channel: 2T+4 clks (FIN plus the IDLE launch clk).
- Reset (async, any state):
  - Return to IDLE. a2d_SS_n=1, SCLK=1, MOSI=0.
  - res=0, res_chnnl=0, cnv_cmplt=0, scan_done=0.
  - All bank entries 0, scan pointer 0.
  - An aborted transaction writes nothing.
- rd_res is purely combinational from the bank and rd_chnnl; a bank write is visible the clk after FIN.

## Test plan
- Single conversion, SCLK_DIV=4, chnnl=5, ADC model returns 0x0ABC → MOSI frames are 0x2800 twice, a2d_SS_n low 65 clks per frame with a 2-clk gap, cnv_cmplt rises at clk 133, res=0xABC, res_chnnl=5, rd_res(5)=0xABC.
- Scan, NUM_CHNNL=4, ADC returns 0x100+ch → bank[0..3]=0x100..0x103, scan_done pulses once per sweep (every 4*(2T+4) clks), pointer wraps to 0.
- strt_cnv and scan_en both high in IDLE with chnnl=6 and pointer=2 → channel 6 converts first, pointer stays 2, channel 2 converts next.
- scan_en dropped during TX1 of channel 1 → channel 1 completes and is stored, bus stays idle, re-enabling resumes at channel 2.
- strt_cnv pulsed during TX2 → ignored; exactly one cnv_cmplt occurs and the frame count is 2.
- rst asserted mid-TX1 → a2d_SS_n and SCLK go high immediately, all outputs and bank read 0, and a new strt_cnv after rst release completes normally.
